// File: rtl/synth_pkg.sv
// rtl/synth_pkg.sv - shared note/divider constants and voice table types
// Purpose: common widths, note index constants and the per-voice table
// entry used by the voice scheduler and its helpers.
package synth_pkg;

    localparam int NUM_NOTES = 12;
    localparam int NOTE_W    = 4;
    localparam int DIV_W     = 16;

    typedef struct packed {
        logic              valid;
        logic [NOTE_W-1:0] note;
    } voice_t;

    localparam logic [NOTE_W-1:0] NOTE_C  = 4'd0;
    localparam logic [NOTE_W-1:0] NOTE_CS = 4'd1;
    localparam logic [NOTE_W-1:0] NOTE_D  = 4'd2;
    localparam logic [NOTE_W-1:0] NOTE_DS = 4'd3;
    localparam logic [NOTE_W-1:0] NOTE_E  = 4'd4;
    localparam logic [NOTE_W-1:0] NOTE_F  = 4'd5;
    localparam logic [NOTE_W-1:0] NOTE_FS = 4'd6;
    localparam logic [NOTE_W-1:0] NOTE_G  = 4'd7;
    localparam logic [NOTE_W-1:0] NOTE_GS = 4'd8;
    localparam logic [NOTE_W-1:0] NOTE_A  = 4'd9;
    localparam logic [NOTE_W-1:0] NOTE_AS = 4'd10;
    localparam logic [NOTE_W-1:0] NOTE_B  = 4'd11;

endpackage

// File: rtl/free_voice_finder.sv
// rtl/free_voice_finder.sv - lowest-index free voice priority encoder
// Purpose: combinational search over the voice valid bits.
// Ports:
//   valid  in   N      1 = voice busy
//   found  out  1      at least one voice is free
//   idx    out  IDX_W  lowest-numbered free voice (0 when none)
module free_voice_finder #(
    parameter int N     = 4,
    parameter int IDX_W = 2
) (
    input  logic [N-1:0]     valid,
    output logic             found,
    output logic [IDX_W-1:0] idx
);

    // Walk downward so the lowest free index is the last one written.
    always_comb begin
        found = 1'b0;
        idx   = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (!valid[i]) begin
                found = 1'b1;
                idx   = IDX_W'(i);
            end
        end
    end

endmodule

// File: rtl/voice_scheduler.sv
// rtl/voice_scheduler.sv - polyphonic key-to-voice allocator
// Purpose: scans the 12-key bitmap one key per cycle, assigns pressed keys
// to the lowest free voice, frees voices on release and drives each voice's
// divider count from the divider outputs.
// Ports:
//   clk         in   1                 system clock
//   rst         in   1                 synchronous active-high reset
//   keys        in   12                debounced key levels, bit n = note n
//   div_in      in   12*16             divider counts, note n at [16n+15:16n]
//   voice_gate  out  NUM_VOICES        voice holds a note
//   voice_note  out  NUM_VOICES*4      note held by voice (0 when free)
//   voice_div   out  NUM_VOICES*16     count for voice (0 when free)
//   note_on     out  NUM_VOICES        one-cycle assignment strobe
//   full        out  1                 all voices busy
module voice_scheduler
    import synth_pkg::*;
#(
    parameter int NUM_VOICES = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_NOTES-1:0]          keys,
    input  logic [NUM_NOTES*DIV_W-1:0]    div_in,
    output logic [NUM_VOICES-1:0]         voice_gate,
    output logic [NUM_VOICES*NOTE_W-1:0]  voice_note,
    output logic [NUM_VOICES*DIV_W-1:0]   voice_div,
    output logic [NUM_VOICES-1:0]         note_on,
    output logic                          full
);

    localparam int IDX_W = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;

    logic [NOTE_W-1:0]             scan_idx;
    voice_t [NUM_VOICES-1:0]       table_q;
    voice_t [NUM_VOICES-1:0]       table_d;
    logic [NUM_VOICES-1:0]         valid_q;
    logic [NUM_VOICES-1:0]         valid_d;
    logic [NUM_VOICES-1:0]         note_on_q;
    logic [NUM_VOICES-1:0]         note_on_d;
    logic [NUM_VOICES*DIV_W-1:0]   div_q;
    logic [NUM_VOICES*DIV_W-1:0]   div_d;
    logic                          full_q;

    logic                          key_now;
    logic                          hit;
    logic [IDX_W-1:0]              hit_idx;
    logic                          free_found;
    logic [IDX_W-1:0]              free_idx;

    always_comb begin
        for (int v = 0; v < NUM_VOICES; v++) begin
            valid_q[v]                         = table_q[v].valid;
            voice_note[v*NOTE_W +: NOTE_W]     = table_q[v].note;
        end
    end

    free_voice_finder #(
        .N     (NUM_VOICES),
        .IDX_W (IDX_W)
    ) u_free_voice_finder (
        .valid (valid_q),
        .found (free_found),
        .idx   (free_idx)
    );

    // Only the key under the scan pointer is examined, so at most one
    // table entry changes per cycle.
    always_comb begin
        key_now   = keys[scan_idx];
        hit       = 1'b0;
        hit_idx   = '0;
        for (int v = 0; v < NUM_VOICES; v++) begin
            if (table_q[v].valid && (table_q[v].note == scan_idx)) begin
                hit     = 1'b1;
                hit_idx = IDX_W'(v);
            end
        end

        table_d   = table_q;
        note_on_d = '0;
        if (key_now && !hit && free_found) begin
            table_d[free_idx].valid = 1'b1;
            table_d[free_idx].note  = scan_idx;
            note_on_d[free_idx]     = 1'b1;
        end else if (!key_now && hit) begin
            table_d[hit_idx] = '0;
        end

        // Counts follow the post-update table so voice_div lines up with
        // voice_gate, and a div_in change lands one cycle later.
        for (int v = 0; v < NUM_VOICES; v++) begin
            valid_d[v]                 = table_d[v].valid;
            div_d[v*DIV_W +: DIV_W]    = '0;
            if (table_d[v].valid) begin
                for (int j = 0; j < NUM_NOTES; j++) begin
                    if (table_d[v].note == NOTE_W'(j)) begin
                        div_d[v*DIV_W +: DIV_W] = div_in[j*DIV_W +: DIV_W];
                    end
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            scan_idx  <= '0;
            table_q   <= '0;
            note_on_q <= '0;
            div_q     <= '0;
            full_q    <= 1'b0;
        end else begin
            scan_idx  <= (scan_idx == 4'd11) ? 4'd0 : scan_idx + 4'd1;
            table_q   <= table_d;
            note_on_q <= note_on_d;
            div_q     <= div_d;
            full_q    <= &valid_d;
        end
    end

    assign voice_gate = valid_q;
    assign voice_div  = div_q;
    assign note_on    = note_on_q;
    assign full       = full_q;

endmodule

// File: doc/voice_scheduler.md
# voice_scheduler

Polyphonic voice allocator between the keypad and the per-voice tone generators. It scans the 12-key bitmap one key per cycle and assigns pressed keys to a fixed pool of voices. It frees voices on release and drives each voice's count, picked from the frequency divider's 12 outputs for that voice's note. Octave selection stays in the divider; this block only maps notes to voices.

## Interface
- NUM_VOICES, 4: number of simultaneous voices; legal range 1–8.
- clk  in  1  system clock, 10 MHz.
- rst  in  1  synchronous, active-high reset.
- keys  in  12  level key state, already synchronised and debounced; bit n = note n (0 = C … 11 = B).
- div_in  in  12×16  divider counts, packed; note n at bits [16n+15:16n].
- voice_gate  out  NUM_VOICES  1 = voice v currently holds a note.
- voice_note  out  NUM_VOICES×4  note index held by voice v; 0 when free.
- voice_div  out  NUM_VOICES×16  count for voice v; 0 when free.
- note_on  out  NUM_VOICES  one-cycle strobe when voice v is assigned a note.
- full  out  1  all voices busy.

## Operation
- Scan counter `scan_idx` (4 bits) steps 0→11 and wraps to 0, one increment per cycle. It never holds.
- Voice table per voice: `valid` and `note[3:0]`.
- Each cycle, evaluate key k = `scan_idx` only:
  - **Press, unassigned, free voice exists:** keys[k]=1, no valid voice holds note k, at least one voice free.
    - Assign the lowest-numbered free voice: valid←1, note←k.
    - Pulse note_on[v] on the next cycle.
  - **Press, unassigned, no free voice:** keys[k]=1 with all voices valid.
    - No action and no stealing; the key is retried on the next pass.
  - **Release:** keys[k]=0 and voice v holds note k with valid=1.
    - Set valid←0 and note←0.
  - **Otherwise:** no change.
- At most one table change per cycle, so simultaneous presses and releases are serialised by scan order.
- A key is never held by two voices; the lookup for k checks every valid voice.
- voice_div[v] is registered every cycle as valid ? div_in[note] : 0. A divider octave change therefore reaches all active voices one cycle later, with no reassignment.
- full = AND of all valid bits, registered together with the table.
- Reset in mid-operation:
  - All voices freed at once; no note_on issued.
  - scan_idx←0.

## Timing
- Reset values: voice_gate=0, voice_note=0, voice_div=0, note_on=0, full=0, scan_idx=0.
- Key press to gate: the table updates at the edge that ends the scan cycle for that key. voice_gate, voice_note and note_on are visible on the following cycle.
- Press-to-gate latency is 1–12 cycles (worst case 1.2 µs), depending on the scan phase.
- Release to gate low: same 1–12 cycle latency.
- A key pulse shorter than 12 cycles may be missed. This is acceptable because inputs are debounced.
- div_in to voice_div: 1 cycle.
- note_on is high for exactly one cycle per assignment.

## Structure
- Shared package `synth_pkg`:
  - NUM_NOTES=12, NOTE_W=4, DIV_W=16.
  - Packed struct voice_t {valid, note}.
  - Note index constants NOTE_C … NOTE_B.
- Sub-module `free_voice_finder`:
  - Combinational priority encoder over ~valid.
  - Outputs found and idx (lowest index wins).
  - Reusable by a later voice-stealing variant.
- All state lives in one always_ff: scan counter, voice table, output registers.

## Test plan
1. **Reset:** hold rst 2 cycles with keys=12'hFFF.
   - During reset, all outputs 0.
   - After release, voices 0–3 take notes 0,1,2,3 in order within 12 cycles.
   - full=1, and keys 4–11 are ignored.
2. **Single note:** with div_in = divider low-octave values, press only key 9 (A).
   - Within ≤13 cycles: voice_gate=4'b0001, voice_note[0]=9, voice_div[0]=22727, one note_on[0] pulse.
   - Release key 9: gate clears within ≤13 cycles and voice_div[0]=0.
3. **Octave follow:** while key 0 is held on voice 0, change div_in note 0 from 38223 to 19111.
   - voice_div[0]=19111 exactly 1 cycle later; no note_on.
4. **Full / retry:** hold keys 0–3 (full=1), then press key 7.
   - No assignment while full.
   - Release key 2: its voice frees, and key 7 takes that voice on the next scan of index 7.
5. **Duplicate guard / lowest-free:** hold key 5 across 5 full scan passes.
   - Exactly one voice holds note 5 and note_on pulses once.
   - Free voice 1 while voices 0, 2, 3 are busy: the next press lands on voice 1.
6. **Mid-operation reset:** assert rst for 1 cycle with 3 voices active.
   - Next cycle all gates are 0.
   - Held keys reassign from voice 0 upward with fresh note_on pulses.
